// File: rtl/cypher_stream_tx.sv
// cypher_stream_tx: nibble-stream transmitter for the cypher sequence detector.
// Sends up to 16 payload nibbles with a timed read strobe (HOLD high, GAP low)
// and tracks the reference verdict (cypher seen, nibble sum) as it goes.
module cypher_stream_tx #(
  parameter int HOLD_CYCLES = 30,
  parameter int GAP_CYCLES  = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] cypher_in,
  input  logic [63:0] payload_in,
  input  logic [3:0]  len_in,
  output logic [15:0] cypher,
  output logic [3:0]  four_bit_input,
  output logic        read,
  output logic        busy,
  output logic        done,
  output logic        expected_find,
  output logic [7:0]  expected_sum
);

  // The phase counter only has to reach the longer of the two windows.
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_phase;
  logic [15:0]   r_cypher;
  logic [63:0]   r_payload;   // current nibble always sits in [3:0]
  logic [3:0]    r_len;
  logic [3:0]    r_idx;
  logic [15:0]   r_window;    // newest nibble in [15:12]
  logic [2:0]    r_cnt;       // nibbles sent, saturating at 4
  logic          r_find;
  logic [7:0]    r_sum;
  logic          r_read;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic          w_hold_end;
  logic          w_gap_end;
  logic          w_advance;
  logic [15:0]   w_window_next;
  logic [2:0]    w_cnt_next;
  logic          w_match;

  // Window/count as they will be after the current nibble is shifted in;
  // the match is judged on these so find registers on the same edge.
  assign w_window_next = {r_payload[3:0], r_window[15:4]};
  assign w_cnt_next    = (r_cnt == 3'd4) ? 3'd4 : (r_cnt + 3'd1);
  assign w_match       = (w_cnt_next == 3'd4) && (w_window_next == r_cypher);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the per-edge control strobes.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_hold_end   = 1'b0;
    w_gap_end    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (r_phase == HOLD_LAST) begin
          w_hold_end   = 1'b1;
          w_next_state = ST_GAP;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (r_phase == GAP_LAST) begin
          w_gap_end = 1'b1;
          if (r_idx == r_len) begin
            w_next_state = ST_DONE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_HOLD;
          end
        end else begin
          w_next_state = ST_GAP;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Phase counter: restarts at every state change, counts within HOLD/GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= {CW{1'b0}};
    end else if ((w_next_state == r_state) &&
                 ((r_state == ST_HOLD) || (r_state == ST_GAP))) begin
      r_phase <= r_phase + CW'(1);
    end else begin
      r_phase <= {CW{1'b0}};
    end
  end

  // Transfer datapath: latch on start, fold nibble into verdict at HOLD end,
  // step to the next nibble at GAP end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cypher  <= 16'h0000;
      r_payload <= 64'h0;
      r_len     <= 4'd0;
      r_idx     <= 4'd0;
      r_window  <= 16'h0000;
      r_cnt     <= 3'd0;
      r_find    <= 1'b0;
      r_sum     <= 8'd0;
    end else if (w_load) begin
      r_cypher  <= cypher_in;
      r_payload <= payload_in;
      r_len     <= len_in;
      r_idx     <= 4'd0;
      r_window  <= 16'h0000;
      r_cnt     <= 3'd0;
      r_find    <= 1'b0;
      r_sum     <= 8'd0;
    end else if (w_hold_end) begin
      r_window  <= w_window_next;
      r_cnt     <= w_cnt_next;
      r_sum     <= r_sum + {4'h0, r_payload[3:0]};
      r_find    <= r_find | w_match;
    end else if (w_advance) begin
      r_idx     <= r_idx + 4'd1;
      r_payload <= {4'h0, r_payload[63:4]};
    end else begin
      r_idx     <= r_idx;
    end
  end

  // Registered strobes derived from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_read <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_read <= (w_next_state == ST_HOLD);
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign cypher         = r_cypher;
  assign four_bit_input = r_payload[3:0];
  assign read           = r_read;
  assign busy           = r_busy;
  assign done           = r_done;
  assign expected_find  = r_find;
  assign expected_sum   = r_sum;

endmodule

// File: tb/tb_cypher_stream_tx.sv
// Bench for cypher_stream_tx: a cycle-indexed model of the transfer timeline
// checked every cycle, plus hand-computed literal expectations.
module tb_cypher_stream_tx;

  localparam int H = 3;
  localparam int G = 2;
  localparam int P = H + G;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cypher_in = 16'h0;
  logic [63:0] payload_in = 64'h0;
  logic [3:0]  len_in = 4'd0;
  logic [15:0] cypher;
  logic [3:0]  four_bit_input;
  logic        read;
  logic        busy;
  logic        done;
  logic        expected_find;
  logic [7:0]  expected_sum;

  int total = 0;
  int bad   = 0;
  int tb_t  = 0;

  cypher_stream_tx #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cypher_in(cypher_in), .payload_in(payload_in), .len_in(len_in),
    .cypher(cypher), .four_bit_input(four_bit_input), .read(read),
    .busy(busy), .done(done), .expected_find(expected_find),
    .expected_sum(expected_sum)
  );

  // Clock generation.
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, tb_t);
    end
  endtask

  // Model state: mode 0 = after reset (all zero), mode 1 = transfer timeline.
  int          m_mode = 0;
  int          m_t = 0;
  int          m_n = 1;
  logic [15:0] m_cyp = 16'h0;
  logic [3:0]  m_nib [16];

  // Model: a transfer starts when start is seen while idle; then time advances.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
      m_t    <= 0;
    end else if (start && (m_mode == 0 || m_t >= m_n * P + 1)) begin
      m_mode <= 1;
      m_t    <= 0;
      m_cyp  <= cypher_in;
      m_n    <= int'(len_in) + 1;
      for (int i = 0; i < 16; i++) m_nib[i] <= payload_in[4*i +: 4];
    end else if (m_mode == 1) begin
      m_t <= m_t + 1;
    end
  end

  // Every-cycle compare of all outputs against the model timeline.
  always @(negedge clock) begin : cmp
    int k, p, s;
    logic e_read, e_busy, e_done, e_find;
    logic [3:0] e_four;
    logic [7:0] e_sum;
    logic [15:0] e_cyp;
    e_read = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_find = 1'b0;
    e_four = 4'h0; e_sum = 8'h0; e_cyp = 16'h0; s = 0;
    if (m_mode == 1) begin
      e_cyp = m_cyp;
      if (m_t >= m_n * P) begin
        s      = m_n;
        e_four = m_nib[m_n - 1];
        e_done = (m_t == m_n * P);
        e_busy = e_done;
      end else begin
        k      = m_t / P;
        p      = m_t % P;
        e_read = (p < H);
        e_four = m_nib[k];
        s      = k + ((p >= H) ? 1 : 0);
        e_busy = 1'b1;
      end
      for (int j = 0; j < s; j++) e_sum = e_sum + {4'h0, m_nib[j]};
      for (int j = 3; j < s; j++)
        if (m_nib[j-3] == m_cyp[3:0] && m_nib[j-2] == m_cyp[7:4] &&
            m_nib[j-1] == m_cyp[11:8] && m_nib[j] == m_cyp[15:12])
          e_find = 1'b1;
    end
    chk("read", read, e_read);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("four_bit_input", four_bit_input, e_four);
    chk("cypher", cypher, e_cyp);
    chk("expected_sum", expected_sum, e_sum);
    chk("expected_find", expected_find, e_find);
  end

  task automatic next_neg();
    @(negedge clock);
    tb_t++;
  endtask

  task automatic wait_until(input int t);
    while (tb_t < t) next_neg();
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      next_neg();
      if (done === 1'b1) begin
        cyc = tb_t;
        break;
      end
    end
    if (cyc < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got none expected done within %0d cycles", budget);
    end
  endtask

  // Start pulse; returns just after the sampling edge E0 (next negedge is t=0).
  task automatic do_start(input logic [15:0] c, input logic [63:0] pl, input logic [3:0] l);
    @(posedge clock);
    #1;
    cypher_in = c; payload_in = pl; len_in = l; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    tb_t = -1;
  endtask

  localparam logic [63:0] PAY1 = 64'h0026_0112_0143_0310;

  initial begin
    int c;
    int ndone;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sum", expected_sum, 8'h00);

    // Pattern present at end of stream.
    do_start(16'h2601, PAY1, 4'd13);
    wait_until(67);
    chk("t1_find_before", expected_find, 1'b0);
    wait_until(68);
    chk("t1_find_rise", expected_find, 1'b1);
    chk("t1_read_gap", read, 1'b0);
    wait_done(100, c);
    chk("t1_done_time", c, 70);
    chk("t1_sum", expected_sum, 8'd24);
    chk("t1_last_nibble", four_bit_input, 4'h2);

    // Pattern absent.
    do_start(16'h4321, PAY1, 4'd13);
    wait_done(100, c);
    chk("t2_done_time", c, 70);
    chk("t2_sum", expected_sum, 8'd24);
    chk("t2_find", expected_find, 1'b0);

    // Overlap, start ignored mid-HOLD.
    do_start(16'h1111, 64'h0000_0000_0001_1111, 4'd4);
    wait_until(5);
    cypher_in = 16'h0000; payload_in = 64'h0; len_in = 4'd0; start = 1'b1;
    next_neg();
    start = 1'b0;
    wait_until(17);
    chk("t3_find_before", expected_find, 1'b0);
    wait_until(18);
    chk("t3_find_rise", expected_find, 1'b1);
    wait_done(50, c);
    chk("t3_done_time", c, 25);
    chk("t3_find_kept", expected_find, 1'b1);
    chk("t3_cypher_kept", cypher, 16'h1111);
    chk("t3_sum", expected_sum, 8'd5);

    // Single nibble; restart also clears the sticky find.
    do_start(16'h000F, 64'h0000_0000_0000_000F, 4'd0);
    next_neg();
    chk("t4_find_cleared", expected_find, 1'b0);
    chk("t4_read", read, 1'b1);
    chk("t4_nibble", four_bit_input, 4'hF);
    wait_done(20, c);
    chk("t4_done_time", c, 5);
    chk("t4_sum", expected_sum, 8'd15);
    chk("t4_find", expected_find, 1'b0);

    // Full 16-nibble payload, pattern at the very start.
    do_start(16'h3210, 64'hFEDC_BA98_7654_3210, 4'd15);
    wait_done(100, c);
    chk("t5_done_time", c, 80);
    chk("t5_sum", expected_sum, 8'd120);
    chk("t5_find", expected_find, 1'b1);
    chk("t5_last_nibble", four_bit_input, 4'hF);

    // Reset asserted mid-HOLD: outputs clear without a clock edge.
    do_start(16'h2601, PAY1, 4'd13);
    wait_until(1);
    #1 reset = 1'b1;
    #1;
    chk("rst_read", read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cypher", cypher, 16'h0);
    chk("rst_nibble", four_bit_input, 4'h0);
    chk("rst_sum", expected_sum, 8'h0);
    chk("rst_find", expected_find, 1'b0);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    chk("rst_no_done", ndone, 0);

    // Start held high: back-to-back single-nibble transfers, one IDLE cycle apart.
    @(posedge clock);
    #1;
    cypher_in = 16'h0000; payload_in = 64'h7; len_in = 4'd0; start = 1'b1;
    @(posedge clock);
    ndone = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    chk("held_start_dones", ndone, 3);
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cypher_stream_tx.md
# cypher_stream_tx

Nibble-stream transmitter for the cypher sequence detector (`main`). It takes a 16-bit cypher and a payload of up to 16 nibbles, then presents the nibbles one at a time on `four_bit_input`. Each nibble is accompanied by a timed `read` strobe: HIGH for a hold window, then LOW for a gap window. In parallel it computes the reference verdict (expected find, nibble sum), so it serves as both the detector's upstream source and its self-checking stimulus engine.

## Interface

Parameters:
- `HOLD_CYCLES`, 30: clock cycles `read` stays high per nibble; legal range ≥1.
- `GAP_CYCLES`, 30: clock cycles `read` stays low after each nibble; legal range ≥1.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `cypher_in`  in  16  cypher to send and match against.
- `payload_in`  in  64  nibble k = `payload_in[4k+3:4k]`; nibble 0 is sent first.
- `len_in`  in  4  number of nibbles to send, minus 1 (0 → 1 nibble, 15 → 16 nibbles).
- `cypher`  out  16  latched cypher, driven to the detector.
- `four_bit_input`  out  4  current nibble.
- `read`  out  1  nibble-valid strobe.
- `busy`  out  1  high from the start edge until the return to IDLE.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `expected_find`  out  1  sticky flag: the cypher sequence has appeared in the sent stream.
- `expected_sum`  out  8  running sum of the nibbles sent (maximum 16×15 = 240, no overflow).

## Operation

- States: IDLE, HOLD, GAP, DONE.
- IDLE, with `start`=1: latch `cypher_in`, `payload_in` and `len_in`; clear the nibble index, phase counter, match window, `expected_find` and `expected_sum`; go to HOLD.
  - `start` is ignored in every other state.
- HOLD:
  - `read`=1; `four_bit_input` = current nibble.
  - After `HOLD_CYCLES` cycles, go to GAP.
  - On that same edge:
    - shift the nibble into the window: window ← {nibble, window[15:4]};
    - add the nibble to `expected_sum`;
    - increment the count of sent nibbles (saturating at 4).
- GAP:
  - `read`=0; `four_bit_input` keeps the last nibble.
  - After `GAP_CYCLES` cycles: if that nibble was number `len_in`, go to DONE; otherwise advance the index and go to HOLD.
- DONE: `done`=1 for exactly one cycle, `busy`=1; next edge goes to IDLE.
- Match rule:
  - The cypher is sent low nibble first: `cypher[3:0]` must be the oldest of four consecutive nibbles and `cypher[15:12]` the newest.
  - `expected_find` sets when sent-count ≥4 and the window equals the latched cypher.
  - It evaluates on the updated window (combinationally from the next-state value, registered on the same edge).
  - It stays set until the next accepted `start` or `reset`.
  - Overlapping occurrences are allowed. Occurrences that straddle transfers are not detected, because the window clears on start.
- IDLE outputs: `four_bit_input`, `cypher`, `expected_*` keep their last values; `read`=0; `busy`=0.
- Reset values: state IDLE; `cypher`=0, `four_bit_input`=0, `read`=0, `busy`=0, `done`=0, `expected_find`=0, `expected_sum`=0; window and counters 0.
- Reset mid-transfer: `read` drops immediately (asynchronous). No `done` is produced. The transfer is abandoned; a new `start` is required.

## Timing

- Latency:
  - `start` sampled on edge E0 → `read`=1 with nibble 0 in the cycle after E0.
  - Nibble k: `read` high during cycles E0+k(H+G) … E0+k(H+G)+H−1, then low for G cycles.
- `expected_sum` and `expected_find` reflect nibble k from the first GAP cycle of nibble k onward.
- `done` is high in cycle E0+N(H+G), where N=`len_in`+1. `busy` falls one cycle later.
- Earliest re-start: the cycle after the `done` cycle.
- `start` held high continuously: a new transfer begins on the first IDLE edge. There is exactly one IDLE cycle between transfers.
- `len_in`=0: a single HOLD+GAP, then DONE.
- `len_in`=15: all 64 payload bits are sent; no wrap of the index.

## Test plan

- Reset during operation (assert mid-HOLD): `read`=0 in the same cycle without a clock edge; all outputs at 0; `busy`=0; no `done`.
- Pattern present at end of stream:
  - Stimulus: `cypher_in`=16'h2601, `payload_in`=64'h0026_0112_0143_0310, `len_in`=13, `start` pulse.
  - 14 `read` pulses carrying 0,1,3,0,3,4,1,0,2,1,1,0,6,2.
  - `expected_find` rises in the GAP after the 14th nibble; `expected_sum`=24.
  - `done` at E0+14(H+G).
- Pattern absent:
  - Stimulus: same payload with `cypher_in`=16'h4321.
  - `expected_find` stays 0 throughout; `expected_sum`=24.
- Single nibble:
  - Stimulus: `len_in`=0, `payload_in[3:0]`=4'hF, H=G=2.
  - `read` high 2 cycles then low 2 cycles; `expected_sum`=15; `done` at E0+4; `expected_find`=0.
- Overlap and protocol:
  - Stimulus: `cypher_in`=16'h1111, payload of five 1s, `len_in`=4, H=G=2.
  - `expected_find` sets after the 4th nibble and stays set.
  - `start` pulsed during HOLD is ignored.
  - `start` after `done` clears `expected_find` to 0.
